// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider for the execute stage.
// Implements MIPS DIV (signed) and DIVU (unsigned): quotient goes to lo_o and
// remainder goes to hi_o. The unit takes WIDTH iterations plus one
// sign-correction cycle. It holds the pipeline through stallE while it works.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   startE  - a DIV/DIVU instruction is in the E stage
//   signedE - 1 = DIV (two's complement), 0 = DIVU
//   srcaE   - dividend (forwarded)
//   srcbE   - divisor (forwarded)
//   flushE  - E-stage flush, abandons any operation
//   stallE  - stall request to the hazard unit (combinational)
//   ready   - one-cycle pulse while the result is being written
//   busy    - unit is not idle
//   hi_o    - remainder of the last completed division
//   lo_o    - quotient of the last completed division
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             stallE,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt_r;
    logic             qneg_r;
    logic             rneg_r;

    logic             accept_s;
    logic             div_zero_s;
    logic             last_step_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;

    // Two's complement negation at operand width.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand conditioning and the restoring-division trial subtraction.
    always_comb begin
        accept_s    = startE & ~flushE;
        div_zero_s  = (srcbE == {WIDTH{1'b0}});
        last_step_s = (cnt_r == LAST_STEP);
        if (signedE && srcaE[WIDTH-1]) begin
            a_abs_s = negate(srcaE);
        end else begin
            a_abs_s = srcaE;
        end
        if (signedE && srcbE[WIDTH-1]) begin
            b_abs_s = negate(srcbE);
        end else begin
            b_abs_s = srcbE;
        end
        // Shift {rem, quo} left by one: the quotient MSB enters the remainder.
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        // The remainder is always below the divisor, so bit WIDTH of the
        // difference is a reliable borrow (negative) flag.
        trial_s  = rem_sh_s - {1'b0, dvs_r};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (div_zero_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (flushE) begin
                    state_next_s = IDLE;
                end else if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            // startE is ignored here: it is still the same instruction.
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        stallE = ((state_r == IDLE) & accept_s) | (state_r == BUSY);
        ready  = (state_r == DONE) & ~flushE;
        busy   = (state_r != IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture, iteration, and sign-corrected result write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            qneg_r <= 1'b0;
            rneg_r <= 1'b0;
            hi_o   <= {WIDTH{1'b0}};
            lo_o   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r <= {CW{1'b0}};
                        if (div_zero_s) begin
                            // Result is fixed: all-ones quotient, raw dividend
                            // as remainder, no sign correction.
                            quo_r  <= {WIDTH{1'b1}};
                            rem_r  <= srcaE;
                            dvs_r  <= {WIDTH{1'b0}};
                            qneg_r <= 1'b0;
                            rneg_r <= 1'b0;
                        end else begin
                            quo_r  <= a_abs_s;
                            rem_r  <= {WIDTH{1'b0}};
                            dvs_r  <= b_abs_s;
                            qneg_r <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                            rneg_r <= signedE & srcaE[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (trial_s[WIDTH]) begin
                        rem_r <= rem_sh_s[WIDTH-1:0];
                    end else begin
                        rem_r <= trial_s[WIDTH-1:0];
                    end
                    quo_r <= {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
                    cnt_r <= cnt_r + CNT_ONE;
                end
                DONE: begin
                    if (!flushE) begin
                        lo_o <= qneg_r ? negate(quo_r) : quo_r;
                        hi_o <= rneg_r ? negate(rem_r) : rem_r;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit. Inputs change 1 ns
// after the rising edge; outputs are sampled 5 ns after it.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         startE;
    logic         signedE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         flushE;
    logic         stallE;
    logic         ready;
    logic         busy;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .startE  (startE),
        .signedE (signedE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .flushE  (flushE),
        .stallE  (stallE),
        .ready   (ready),
        .busy    (busy),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, then wait to the sampling point of this cycle.
    task automatic drive(input logic st, input logic fl, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
        startE  = st;
        flushE  = fl;
        signedE = sg;
        srcaE   = a;
        srcbE   = b;
        #4;
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One complete division with startE held until DONE; operands are
    // scrambled after the accept cycle.
    task automatic run_div(input vec_t v, input int tag);
        int done_c;
        done_c = (v.b == 32'd0) ? 1 : 33;
        for (int c = 0; c <= done_c + 1; c++) begin
            if (c == 0) drive(1'b1, 1'b0, v.sgn, v.a, v.b);
            else        drive(c <= done_c, 1'b0, v.sgn, $urandom, $urandom);
            chk($sformatf("v%0d stallE c%0d", tag, c), stallE, c < done_c);
            chk($sformatf("v%0d ready c%0d", tag, c), ready, c == done_c);
            chk($sformatf("v%0d busy c%0d", tag, c), busy, (c >= 1) && (c <= done_c));
            if (c == done_c + 1) begin
                chk($sformatf("v%0d lo", tag), lo_o, v.lo);
                chk($sformatf("v%0d hi", tag), hi_o, v.hi);
            end
            adv();
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[7]  = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF};
        vecs[9]  = '{1'b1, 32'd100,        32'h8000_0000,  32'd0,          32'd100};
        vecs[10] = '{1'b0, 32'd9,          32'd4,          32'd2,          32'd1};

        // Reset state.
        rst = 1'b0;
        startE = 1'b0; flushE = 1'b0; signedE = 1'b0; srcaE = 32'd0; srcbE = 32'd0;
        #1 rst = 1'b1;
        #1;
        chk("rst stallE", stallE, 1'b0);
        chk("rst ready", ready, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst hi", hi_o, 32'd0);
        chk("rst lo", lo_o, 32'd0);
        adv();
        adv();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_div(vecs[i], i);

        // Flush in BUSY at cycle 10; previous result 9/4 must survive.
        for (int c = 0; c <= 40; c++) begin
            if (c == 0)       drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
            else if (c < 10)  drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
            else if (c == 10) drive(1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
            else              drive(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
            chk($sformatf("flushB ready c%0d", c), ready, 1'b0);
            if (c == 10) chk("flushB stallE c10", stallE, 1'b1);
            if (c == 11) begin
                chk("flushB busy c11", busy, 1'b0);
                chk("flushB stallE c11", stallE, 1'b0);
                chk("flushB lo", lo_o, 32'd2);
                chk("flushB hi", hi_o, 32'd1);
            end
            adv();
        end

        // Flush in DONE: no ready, result registers untouched.
        for (int c = 0; c <= 34; c++) begin
            drive(c <= 33, c == 33, 1'b0, 32'd100, 32'd7);
            if (c == 33) begin
                chk("flushD busy c33", busy, 1'b1);
                chk("flushD ready c33", ready, 1'b0);
            end
            if (c == 34) begin
                chk("flushD busy c34", busy, 1'b0);
                chk("flushD lo", lo_o, 32'd2);
                chk("flushD hi", hi_o, 32'd1);
            end
            adv();
        end

        // Flush in IDLE blocks acceptance.
        drive(1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
        chk("flushI stallE", stallE, 1'b0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        chk("flushI busy", busy, 1'b0);
        adv();

        // Back-to-back DIVU with startE held: 100/7 then 9/4.
        for (int c = 0; c <= 68; c++) begin
            if (c < 34) drive(c <= 67, 1'b0, 1'b0, (c == 0) ? 32'd100 : 32'd9, (c == 0) ? 32'd7 : 32'd4);
            else        drive(c <= 67, 1'b0, 1'b0, (c == 34) ? 32'd9 : $urandom, (c == 34) ? 32'd4 : $urandom);
            chk($sformatf("b2b stallE c%0d", c), stallE, (c <= 32) || ((c >= 34) && (c <= 66)));
            chk($sformatf("b2b ready c%0d", c), ready, (c == 33) || (c == 67));
            if (c == 34) begin
                chk("b2b lo1", lo_o, 32'd14);
                chk("b2b hi1", hi_o, 32'd2);
            end
            if (c == 68) begin
                chk("b2b lo2", lo_o, 32'd2);
                chk("b2b hi2", hi_o, 32'd1);
            end
            adv();
        end

        // Asynchronous reset in cycle 15 of a division.
        for (int c = 0; c <= 15; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
            if (c == 15) begin
                chk("arst busy before", busy, 1'b1);
                startE = 1'b0;
                rst = 1'b1;
                #1;
                chk("arst busy", busy, 1'b0);
                chk("arst stallE", stallE, 1'b0);
                chk("arst ready", ready, 1'b0);
                chk("arst lo", lo_o, 32'd0);
                chk("arst hi", hi_o, 32'd0);
            end
            adv();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("arst idle after", busy, 1'b0);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
